// File: rtl/rect_gen_pkg.sv
// Shared types and constants for the rectangle point generator.
`default_nettype none

package rect_gen_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      HORIZ = 3'd1,
      VERT  = 3'd2,
      FILL  = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam logic MODE_OUTLINE = 1'b0;
   localparam logic MODE_FILL    = 1'b1;

   // Which edge of an outline pair is being emitted
   typedef enum logic {
      SIDE_FIRST  = 1'b0,
      SIDE_SECOND = 1'b1
   } side_t;

endpackage

`default_nettype wire

// File: rtl/span_counter.sv
// Index counter 0..limit-1; wraps to 0 when advanced on its last value.
`default_nettype none

module span_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             advance,
   input  logic [WIDTH-1:0] limit,
   output logic [WIDTH-1:0] value,
   output logic             last
);

   logic [WIDTH-1:0] value_q;
   logic [WIDTH-1:0] value_d;

   assign last  = (value_q == (limit - WIDTH'(1)));
   assign value = value_q;

   always_comb begin
      value_d = value_q;
      if (clear) begin
         value_d = '0;
      end else if (advance) begin
         value_d = last ? '0 : (value_q + WIDTH'(1));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/rect_point_generator.sv
// Streams rectangle points (outline, or raster when RECT_GEN_FILL_EN is defined)
// over a valid/ready handshake.
`default_nettype none

module rect_point_generator
   import rect_gen_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                    _clock,
   input  logic                    _reset_n,
   input  logic                    _start,
   input  logic signed [WIDTH-1:0] s_x,
   input  logic signed [WIDTH-1:0] s_y,
   input  logic signed [WIDTH-1:0] height,
   input  logic signed [WIDTH-1:0] width,
`ifdef RECT_GEN_FILL_EN
   input  logic                    mode,
`endif
   input  logic                    _ready,
   output logic                    _valid,
   output logic signed [WIDTH-1:0] _out0,
   output logic signed [WIDTH-1:0] _out1,
   output logic                    _done
);

   state_t           state_q, state_d;
   side_t            side_q, side_d;
   logic [WIDTH-1:0] sx_q, sx_d;
   logic [WIDTH-1:0] sy_q, sy_d;
   logic [WIDTH-1:0] h_q, h_d;
   logic [WIDTH-1:0] w_q, w_d;

   logic             i_clr, i_adv, i_last;
   logic             j_clr, j_adv, j_last;
   logic [WIDTH-1:0] i_val, j_val;

   logic             accept;
   logic             empty;
   logic             beat;

   span_counter #(.WIDTH(WIDTH)) u_col (
      .clk     (_clock),
      .rst_n   (_reset_n),
      .clear   (i_clr),
      .advance (i_adv),
      .limit   (w_q),
      .value   (i_val),
      .last    (i_last)
   );

   span_counter #(.WIDTH(WIDTH)) u_row (
      .clk     (_clock),
      .rst_n   (_reset_n),
      .clear   (j_clr),
      .advance (j_adv),
      .limit   (h_q),
      .value   (j_val),
      .last    (j_last)
   );

   assign accept = _start && ((state_q == IDLE) || (state_q == DONE));
   // Either non-positive dimension makes the whole rectangle empty
   assign empty  = (width <= 0) || (height <= 0);
   assign beat   = _valid && _ready;

   always_comb begin
      state_d = state_q;
      side_d  = side_q;
      sx_d    = sx_q;
      sy_d    = sy_q;
      h_d     = h_q;
      w_d     = w_q;
      i_clr   = 1'b0;
      i_adv   = 1'b0;
      j_clr   = 1'b0;
      j_adv   = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            if (accept) begin
               sx_d   = s_x;
               sy_d   = s_y;
               h_d    = height;
               w_d    = width;
               i_clr  = 1'b1;
               j_clr  = 1'b1;
               side_d = SIDE_FIRST;
               if (empty) begin
                  state_d = DONE;
               end else begin
`ifdef RECT_GEN_FILL_EN
                  state_d = (mode == MODE_FILL) ? FILL : HORIZ;
`else
                  state_d = HORIZ;
`endif
               end
            end
         end
         HORIZ: begin
            if (beat) begin
               if (side_q == SIDE_SECOND) begin
                  side_d = SIDE_FIRST;
                  i_adv  = 1'b1;
                  if (i_last) begin
                     state_d = VERT;
                  end
               end else begin
                  side_d = SIDE_SECOND;
               end
            end
         end
         VERT: begin
            if (beat) begin
               if (side_q == SIDE_SECOND) begin
                  side_d = SIDE_FIRST;
                  j_adv  = 1'b1;
                  if (j_last) begin
                     state_d = DONE;
                  end
               end else begin
                  side_d = SIDE_SECOND;
               end
            end
         end
`ifdef RECT_GEN_FILL_EN
         FILL: begin
            if (beat) begin
               i_adv = 1'b1;
               if (i_last) begin
                  j_adv = 1'b1;
                  if (j_last) begin
                     state_d = DONE;
                  end
               end
            end
         end
`endif
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      _valid = 1'b0;
      _out0  = '0;
      _out1  = '0;
      case (state_q)
         HORIZ: begin
            _valid = 1'b1;
            _out0  = sx_q + i_val;
            _out1  = (side_q == SIDE_SECOND) ? (sy_q + h_q - WIDTH'(1)) : sy_q;
         end
         VERT: begin
            _valid = 1'b1;
            _out0  = (side_q == SIDE_SECOND) ? (sx_q + w_q - WIDTH'(1)) : sx_q;
            _out1  = sy_q + j_val;
         end
`ifdef RECT_GEN_FILL_EN
         FILL: begin
            _valid = 1'b1;
            _out0  = sx_q + i_val;
            _out1  = sy_q + j_val;
         end
`endif
         default: begin
            _valid = 1'b0;
         end
      endcase
   end

   assign _done = (state_q == DONE);

   always_ff @(posedge _clock or negedge _reset_n) begin
      if (!_reset_n) begin
         state_q <= IDLE;
         side_q  <= SIDE_FIRST;
         sx_q    <= '0;
         sy_q    <= '0;
         h_q     <= '0;
         w_q     <= '0;
      end else begin
         state_q <= state_d;
         side_q  <= side_d;
         sx_q    <= sx_d;
         sy_q    <= sy_d;
         h_q     <= h_d;
         w_q     <= w_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_rect_point_generator.sv
// Scoreboard bench for rect_point_generator at WIDTH=8 (fits all directed cases, exercises wrap).
`default_nettype none

module tb_rect_point_generator;

   localparam int W = 8;

   logic                clk;
   logic                rst_n;
   logic                start;
   logic                ready;
   logic signed [W-1:0] sx, sy, hgt, wid;
`ifdef RECT_GEN_FILL_EN
   logic                mode;
`endif
   logic                valid;
   logic                done;
   logic signed [W-1:0] o0, o1;

   int n_vec  = 0;
   int n_miss = 0;
   logic [2*W-1:0] exp_q[$];

   rect_point_generator #(.WIDTH(W)) dut (
      ._clock   (clk),
      ._reset_n (rst_n),
      ._start   (start),
      .s_x      (sx),
      .s_y      (sy),
      .height   (hgt),
      .width    (wid),
`ifdef RECT_GEN_FILL_EN
      .mode     (mode),
`endif
      ._ready   (ready),
      ._valid   (valid),
      ._out0    (o0),
      ._out1    (o1),
      ._done    (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: every beat is compared against the head of the scoreboard
   always @(negedge clk) begin
      if (rst_n && valid && ready) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_miss++;
            $display("FAIL point: unexpected beat got (%0d,%0d), none expected", o0, o1);
         end else begin
            logic [2*W-1:0] e;
            e = exp_q.pop_front();
            if ({o0, o1} !== e) begin
               n_miss++;
               $display("FAIL point: got (%0d,%0d) expected (%0d,%0d)",
                        o0, o1, $signed(e[2*W-1:W]), $signed(e[W-1:0]));
            end
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_miss++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push(input int x, input int y);
      logic [W-1:0] xv, yv;
      xv = W'(x);
      yv = W'(y);
      exp_q.push_back({xv, yv});
   endtask

   task automatic push_outline(input int x, input int y, input int h, input int w);
      for (int i = 0; i < w; i++) begin
         push(x + i, y);
         push(x + i, y + h - 1);
      end
      for (int j = 0; j < h; j++) begin
         push(x, y + j);
         push(x + w - 1, y + j);
      end
   endtask

   task automatic start_rect(input int x, input int y, input int h, input int w);
      @(posedge clk);
      #1;
      sx    = W'(x);
      sy    = W'(y);
      hgt   = W'(h);
      wid   = W'(w);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int max, input bit toggle);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < max && !seen; k++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
         end else if (toggle) begin
            @(posedge clk);
            #1;
            ready = ~ready;
         end
      end
      ready = 1'b1;
      check({name, "_done_seen"}, int'(seen), 1);
      check({name, "_all_points"}, exp_q.size(), 0);
      check({name, "_valid_low"}, int'(valid), 0);
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      ready = 1'b1;
      sx = '0; sy = '0; hgt = '0; wid = '0;
`ifdef RECT_GEN_FILL_EN
      mode = 1'b0;
`endif
      #3;
      check("rst_valid", int'(valid), 0);
      check("rst_done", int'(done), 0);
      check("rst_out0", int'(o0), 0);
      check("rst_out1", int'(o1), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // 1: basic outline, 24 points
      push_outline(23, 17, 5, 7);
      start_rect(23, 17, 5, 7);
      @(negedge clk);
      check("t1_done_cleared", int'(done), 0);
      wait_done("t1", 100, 1'b0);

      // 2: stall on the second point
      push_outline(23, 17, 5, 7);
      start_rect(23, 17, 5, 7);
      @(posedge clk);
      #1;
      ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("t2_hold_valid", int'(valid), 1);
         check("t2_hold_x", int'(o0), 23);
         check("t2_hold_y", int'(o1), 21);
      end
      @(posedge clk);
      #1;
      ready = 1'b1;
      wait_done("t2", 100, 1'b0);

      // 3: empty rectangles, then a normal one
      start_rect(23, 17, 5, 0);
      @(negedge clk);
      check("t3_empty_w_done", int'(done), 1);
      check("t3_empty_w_valid", int'(valid), 0);
      start_rect(23, 17, -1, 3);
      @(negedge clk);
      check("t3_empty_h_done", int'(done), 1);
      check("t3_empty_h_valid", int'(valid), 0);
      push(-3, 4); push(-3, 5);
      push(-3, 4); push(-3, 4);
      push(-3, 5); push(-3, 5);
      start_rect(-3, 4, 2, 1);
      wait_done("t3", 50, 1'b0);

      // 4: coordinate wrap at WIDTH=8 with ready toggling
      push(126, -2); push(126, -2);
      push(127, -2); push(127, -2);
      push(-128, -2); push(-128, -2);
      push(-127, -2); push(-127, -2);
      push(126, -2); push(-127, -2);
      start_rect(126, -2, 1, 4);
      wait_done("t4", 100, 1'b1);

      // 5: start while busy is ignored, then mid-stream reset
      push(23, 17); push(23, 21); push(24, 17);
      push(24, 21); push(25, 17); push(25, 21);
      start_rect(23, 17, 5, 7);
      repeat (5) @(posedge clk);
      #1;
      wid   = 8'sd2;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wid   = 8'sd7;
      rst_n = 1'b0;
      #1;
      check("t5_rst_valid", int'(valid), 0);
      check("t5_rst_done", int'(done), 0);
      check("t5_rst_out0", int'(o0), 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("t5_idle_valid", int'(valid), 0);
      check("t5_idle_done", int'(done), 0);
      check("t5_sixth_point", exp_q.size(), 0);

`ifdef RECT_GEN_FILL_EN
      // 6: filled raster
      mode = 1'b1;
      push(0, 0); push(1, 0); push(2, 0);
      push(0, 1); push(1, 1); push(2, 1);
      start_rect(0, 0, 2, 3);
      wait_done("t6", 50, 1'b0);
      mode = 1'b0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

`default_nettype wire
